// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Initiator-side controller for an 8-bank data memory (1K words per bank).
// It takes one load/store at a time from the core, drives a one-hot bank
// enable with address/data/direction, waits out the bank read latency for
// loads and returns a response. Saturating load/store counters are kept
// for profiling.

module dmem_access_ctrl #(
    parameter int RD_LAT = 1,   // bank read latency in cycles, 1..7
    parameter int CNT_W  = 16   // width of each transaction counter
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [12:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_write,
    output logic [31:0]      resp_rdata,
    output logic [7:0]       mem_enable,
    output logic [9:0]       mem_address,
    output logic [31:0]      mem_data_in,
    output logic             mem_read_write,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // The latency counter is 3 bits wide, which covers the legal 1..7 range.
    localparam logic [2:0]       LAT_LOAD = 3'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t     state_r;
    logic       write_r;   // captured direction of the transaction in flight
    logic [2:0] lat_r;     // remaining read-latency cycles in WAIT

    // Bank number to one-hot chip enable; a 3-bit index can never yield all-ones.
    function automatic logic [7:0] bank_decode(input logic [2:0] bank);
        bank_decode = 8'b0000_0001 << bank;
    endfunction

    // Saturating increment for the profiling counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_ONE;
        end
    endfunction

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            write_r        <= 1'b0;
            lat_r          <= 3'd0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_write     <= 1'b0;
            resp_rdata     <= 32'h0000_0000;
            mem_enable     <= 8'h00;
            mem_address    <= 10'h000;
            mem_data_in    <= 32'h0000_0000;
            mem_read_write <= 1'b0;
            rd_count       <= {CNT_W{1'b0}};
            wr_count       <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    mem_enable     <= 8'h00;
                    mem_read_write <= 1'b0;
                    resp_valid     <= 1'b0;
                    if (req_valid && req_ready) begin
                        // Capture the request straight into the bank-side
                        // registers so they are valid in the ISSUE cycle.
                        mem_enable     <= bank_decode(req_addr[12:10]);
                        mem_address    <= req_addr[9:0];
                        mem_data_in    <= req_wdata;
                        mem_read_write <= req_write;
                        write_r        <= req_write;
                        req_ready      <= 1'b0;
                        state_r        <= ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end

                ISSUE: begin
                    req_ready <= 1'b0;
                    if (write_r) begin
                        // Store completes after a single enable pulse.
                        mem_enable     <= 8'h00;
                        mem_read_write <= 1'b0;
                        resp_rdata     <= 32'h0000_0000;
                        resp_write     <= 1'b1;
                        resp_valid     <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        // Load keeps the bank enabled while data is in flight.
                        mem_read_write <= 1'b0;
                        lat_r          <= LAT_LOAD;
                        state_r        <= WAIT;
                    end
                end

                WAIT: begin
                    req_ready <= 1'b0;
                    if (lat_r <= 3'd1) begin
                        // This is the cycle RD_LAT cycles after ISSUE: sample now.
                        resp_rdata     <= mem_rdata;
                        resp_write     <= 1'b0;
                        resp_valid     <= 1'b1;
                        mem_enable     <= 8'h00;
                        mem_read_write <= 1'b0;
                        lat_r          <= 3'd0;
                        state_r        <= RESP;
                    end else begin
                        lat_r <= lat_r - 3'd1;
                    end
                end

                RESP: begin
                    mem_enable     <= 8'h00;
                    mem_read_write <= 1'b0;
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state_r    <= IDLE;
                        if (write_r) begin
                            wr_count <= sat_inc(wr_count);
                        end else begin
                            rd_count <= sat_inc(rd_count);
                        end
                    end else begin
                        // Back-pressure: hold the response untouched.
                        req_ready <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    state_r        <= IDLE;
                    req_ready      <= 1'b0;
                    resp_valid     <= 1'b0;
                    mem_enable     <= 8'h00;
                    mem_read_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed steps plus random
// load/store traffic against a word-addressed reference memory and
// saturating reference counters. A small bank model answers reads with
// the right word only in the cycle RD_LAT after the read is presented.

module tb_dmem_access_ctrl;

    localparam int RD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_write = 1'b0;
    logic [12:0]      req_addr = 13'h0000;
    logic [31:0]      req_wdata = 32'h0000_0000;
    logic             resp_ready = 1'b0;
    logic [31:0]      mem_rdata = 32'h0000_0000;
    logic             req_ready;
    logic             resp_valid;
    logic             resp_write;
    logic [31:0]      resp_rdata;
    logic [7:0]       mem_enable;
    logic [9:0]       mem_address;
    logic [31:0]      mem_data_in;
    logic             mem_read_write;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    dmem_access_ctrl #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_write(resp_write), .resp_rdata(resp_rdata),
        .mem_enable(mem_enable), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
        .mem_rdata(mem_rdata), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Cycle index used by the bank model to time read data.
    always @(posedge clk) cyc <= cyc + 1;

    // Contents of a word that was never written.
    function automatic logic [31:0] init_val(input int idx);
        init_val = (32'(idx) * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // ---------------- bank model ----------------
    logic [31:0] bank_mem [int];
    logic [7:0]  prev_en = 8'h00;
    int          tgt_cyc = -1;
    int          tgt_idx = 0;

    // Banks: write on an enabled write cycle, return read data only RD_LAT cycles after the read starts.
    always @(negedge clk) begin
        int b;
        b = 0;
        for (int i = 0; i < 8; i++) if (mem_enable[i] === 1'b1) b = i;
        if (mem_enable != 8'h00 && mem_read_write === 1'b1)
            bank_mem[b * 1024 + int'(mem_address)] = mem_data_in;
        if (mem_enable != 8'h00 && prev_en == 8'h00 && mem_read_write === 1'b0) begin
            tgt_cyc = cyc + RD_LAT;
            tgt_idx = b * 1024 + int'(mem_address);
        end
        prev_en = mem_enable;
        if (cyc == tgt_cyc)
            mem_rdata = bank_mem.exists(tgt_idx) ? bank_mem[tgt_idx] : init_val(tgt_idx);
        else
            mem_rdata = $urandom;
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    int ref_rd = 0;
    int ref_wr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction; starts and ends at a falling edge.
    task automatic do_txn(input logic wr, input logic [12:0] addr, input logic [31:0] wd,
                          input int bp, input bit hold, input bit immediate);
        logic [31:0] exp_rd;
        logic [7:0]  exp_en;
        int n;
        exp_en = 8'h01 << addr[12:10];
        if (wr) exp_rd = 32'h0000_0000;
        else exp_rd = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : init_val(int'(addr));
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        if (immediate) chk("accept_next_cycle", 32'(req_ready), 32'd1);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
        chk("issue_en", 32'(mem_enable), 32'(exp_en));
        chk("issue_addr", 32'(mem_address), 32'(addr[9:0]));
        chk("issue_rw", 32'(mem_read_write), 32'(wr));
        if (wr) chk("issue_wdata", mem_data_in, wd);
        chk("issue_req_ready", 32'(req_ready), 32'd0);
        chk("issue_resp_valid", 32'(resp_valid), 32'd0);
        if (!wr) begin
            for (int k = 1; k <= RD_LAT; k++) begin
                @(negedge clk);
                chk("wait_en", 32'(mem_enable), 32'(exp_en));
                chk("wait_rw", 32'(mem_read_write), 32'd0);
                chk("wait_resp_valid", 32'(resp_valid), 32'd0);
            end
        end
        @(negedge clk);
        if (wr) ref_mem[int'(addr)] = wd;
        for (int k = 0; k <= bp; k++) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_write", 32'(resp_write), 32'(wr));
            chk("resp_rdata", resp_rdata, exp_rd);
            chk("resp_en_off", 32'(mem_enable), 32'd0);
            chk("resp_rw_off", 32'(mem_read_write), 32'd0);
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            if (k < bp) @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        if (wr) ref_wr = (ref_wr < CNT_SAT) ? ref_wr + 1 : ref_wr;
        else ref_rd = (ref_rd < CNT_SAT) ? ref_rd + 1 : ref_rd;
        @(negedge clk);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_en", 32'(mem_enable), 32'd0);
        chk("idle_addr_hold", 32'(mem_address), 32'(addr[9:0]));
        chk("rd_count", 32'(rd_count), 32'(ref_rd));
        chk("wr_count", 32'(wr_count), 32'(ref_wr));
    endtask

    // Directed and random stimulus, then the summary.
    initial begin
        logic [2:0]  rb;
        logic [2:0]  rw;
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_write", 32'(resp_write), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_en", 32'(mem_enable), 32'd0);
        chk("rst_rw", 32'(mem_read_write), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_wdata", mem_data_in, 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Store to bank 7, read it back, then a load from untouched bank 2.
        do_txn(1'b1, 13'h1C05, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
        do_txn(1'b0, 13'h1C05, 32'h0000_0000, 0, 1'b0, 1'b0);
        do_txn(1'b0, 13'h0800, 32'h0000_0000, 0, 1'b0, 1'b0);

        // Back-pressure with req_valid held high; next request goes in right after.
        do_txn(1'b1, 13'h0A10, 32'h1111_2222, 5, 1'b1, 1'b0);
        do_txn(1'b0, 13'h0A10, 32'h0000_0000, 0, 1'b0, 1'b1);

        // Random traffic over a small address set so loads hit earlier stores.
        for (int i = 0; i < 40; i++) begin
            rb = 3'($urandom_range(0, 7));
            rw = 3'($urandom_range(0, 7));
            do_txn(1'($urandom_range(0, 1)), {rb, 7'd0, rw}, $urandom,
                   int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        // Reset while a load sits in WAIT.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'h0404;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        ref_rd = 0;
        ref_wr = 0;
        chk("mid_rst_en", 32'(mem_enable), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
        chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < 2 * RD_LAT; k++) begin
            @(negedge clk);
            chk("no_stale_resp", 32'(resp_valid), 32'd0);
            chk("no_stale_en", 32'(mem_enable), 32'd0);
        end

        // Request and reset together: reset wins, nothing is written.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'h1FFF; req_wdata = 32'hBAD0_BAD0;
        reset = 1'b1;
        @(negedge clk);
        chk("simul_en", 32'(mem_enable), 32'd0);
        chk("simul_req_ready", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("simul_ready_after", 32'(req_ready), 32'd1);
        chk("simul_no_issue", 32'(mem_enable), 32'd0);
        do_txn(1'b0, 13'h1FFF, 32'h0000_0000, 0, 1'b0, 1'b0);

        // Twenty stores rotating through the banks saturate the write counter.
        for (int i = 0; i < 20; i++) begin
            do_txn(1'b1, {3'(i % 8), 10'(i * 37)}, $urandom, 0, 1'b0, 1'b0);
        end
        chk("wr_saturated", 32'(wr_count), 32'(CNT_SAT));
        do_txn(1'b0, {3'd3, 10'(3 * 37)}, 32'h0000_0000, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
